// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC generation, ROM latency tracking, 2-entry output FIFO.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0,
    parameter int          DEPTH     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_instr_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        busy_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    state_e      state_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q;
    logic        inflight_q;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_q, wr_q;
    logic [31:0] mem_instr_q [2];
    logic [31:0] mem_pc_q [2];

    logic issue, push, pop;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Slots already claimed: buffered words plus the one still in the ROM.
    assign issue = (state_q == FETCH) && !halt_i && !redirect_i
                && (({1'b0, cnt_q} + {2'b00, inflight_q}) < DEPTH_C);
    assign push  = inflight_q && !redirect_i;
    assign pop   = valid_o && ready_i;

    assign rom_addr_o = pc_q;
    assign valid_o    = (cnt_q != 2'd0);
    assign busy_o     = inflight_q || (cnt_q != 2'd0);
    assign instr_o    = mem_instr_q[rd_q];
    assign pc_o       = mem_pc_q[rd_q];

    // Next PC and FIFO occupancy; redirect overrides everything.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (redirect_i) begin
            pc_d  = {redirect_pc_i[31:2], 2'b00};
            cnt_d = 2'd0;
        end else begin
            if (issue) pc_d = pc_q + 32'd4;
            if (push && !pop) cnt_d = cnt_q + 2'd1;
            if (!push && pop) cnt_d = cnt_q - 2'd1;
        end
    end

    // Sequencer FSM with PC, issue tag and in-flight tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= BOOT_ADDR;
            tag_q      <= 32'h0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) tag_q <= pc_q;
            unique case (state_q)
                IDLE:    state_q <= FETCH;
                FETCH:   if (halt_i) state_q <= HALT;
                HALT:    if (!halt_i) state_q <= FETCH;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output FIFO storage and pointers; redirect flushes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_instr_q[i] <= 32'h0;
                mem_pc_q[i]    <= 32'h0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (redirect_i) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_instr_q[wr_q] <= rom_instr_i;
                    mem_pc_q[wr_q]    <= tag_q;
                    wr_q              <= ~wr_q;
                end
                if (pop) rd_q <= ~rd_q;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Transfer and back-pressure counters; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (pop) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (valid_o && !ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign fetch_cnt_o = 32'h0;
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model, directed phases
// followed by randomized ready/halt/redirect traffic.
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_instr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        halt_i = 1'b0;
    logic        busy_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    int nchk = 0;
    int npass = 0;

    // reference model state
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    fetch_ctrl #(.BOOT_ADDR(32'h0), .DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rom_addr_o   (rom_addr_o),
        .rom_instr_i  (rom_instr_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .halt_i       (halt_i),
        .busy_o       (busy_o),
        .fetch_cnt_o  (fetch_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // registered ROM: word appears one cycle after the address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rom_instr_i <= 32'h0;
        else rom_instr_i <= rom_f(rom_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_mode = 0;
        m_fifo.delete();
        m_pend.delete();
        m_fcnt = 32'h0;
        m_scnt = 32'h0;
    endtask

    task automatic check_outputs();
        logic mv;
        mv = (m_fifo.size() != 0);
        check("valid", {31'h0, valid_o}, {31'h0, mv});
        check("busy", {31'h0, busy_o},
              {31'h0, (m_fifo.size() + m_pend.size()) != 0});
        check("rom_addr", rom_addr_o, m_pc);
        if (mv) begin
            check("pc", pc_o, m_fifo[0]);
            check("instr", instr_o, rom_f(m_fifo[0]));
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt_o, m_fcnt);
        check("stall_cnt", stall_cnt_o, m_scnt);
`else
        check("fetch_cnt", fetch_cnt_o, 32'h0);
        check("stall_cnt", stall_cnt_o, 32'h0);
`endif
    endtask

    // one clock: check, drive, advance model, cross the edge
    task automatic step(input logic rdy, input logic hlt, input logic rdr,
                        input logic [31:0] tgt);
        logic mv, iss, pop;
        check_outputs();
        ready_i = rdy;
        halt_i = hlt;
        redirect_i = rdr;
        redirect_pc_i = tgt;
        mv = (m_fifo.size() != 0);
        pop = mv && rdy;
        iss = (m_mode == 1) && !hlt && !rdr
           && ((m_fifo.size() + m_pend.size()) < 2);
        if (pop) m_fcnt = m_fcnt + 1;
        if (mv && !rdy) m_scnt = m_scnt + 1;
        if (rdr) begin
            m_fifo.delete();
            m_pend.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_pend.size() != 0) m_fifo.push_back(m_pend.pop_front());
            if (iss) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && hlt) m_mode = 2;
        else if (m_mode == 2 && !hlt) m_mode = 1;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        logic h;
        logic [31:0] t;
        model_reset();
        #1;
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_addr", rom_addr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_fcnt", fetch_cnt_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // streaming with ready held high
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        // back-pressure fills the FIFO
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
        // redirect to unaligned target
        step(1'b1, 1'b0, 1'b1, 32'h0000_003E);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
        // halt for four cycles, then resume
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
        // wrap-around at the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
        // redirect while halted
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);

        // randomized traffic
        h = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) h = ~h;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
            step($urandom_range(0, 3) != 0, h,
                 $urandom_range(0, 19) == 0, t);
        end

        // fill the FIFO, then reset asynchronously
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
        check_outputs();
        check("pre_rst_valid", {31'h0, valid_o}, 32'h1);
        #1;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("arst_valid", {31'h0, valid_o}, 32'h0);
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        check("arst_addr", rom_addr_o, 32'h0);
        check("arst_fcnt", fetch_cnt_o, 32'h0);
        check("arst_scnt", stall_cnt_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
